// File: rtl/cache_def.sv
// Types shared between the upstream cache FSM and its backing-memory controller.
package cache_def;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  localparam int unsigned MEM_LATENCY_DEFAULT = 4;

  typedef enum logic [1:0] {MC_IDLE, MC_WAIT, MC_RESP} mem_ctrl_state_type;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_line_store_upstream.sv
// Single-port 128-bit line store with registered read data.
// The contents survive reset; only the read register is cleared.
module mem_line_store_upstream #(
  parameter int unsigned LINES_LOG2 = 10,
  parameter logic [31:0] INIT_WORD  = 32'hfefe0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LINES_LOG2-1:0] index,
  input  logic                  we,
  input  logic [127:0]          wdata,
  input  logic                  re,
  output logic [127:0]          rdata
);

  localparam int unsigned DEPTH = 1 << LINES_LOG2;

  logic [127:0] mem [0:DEPTH-1];
  logic [127:0] rdata_reg;

  // Power-on image of the backing memory.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = {4{INIT_WORD}};
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[index];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/line_mem_ctrl_upstream.sv
// Fixed-latency backing-memory controller answering one 128-bit line
// request at a time with a single-cycle ready pulse.
module line_mem_ctrl_upstream
  import cache_def::*;
#(
  parameter int unsigned LATENCY    = MEM_LATENCY_DEFAULT,
  parameter int unsigned LINES_LOG2 = 10,
  parameter logic [31:0] INIT_WORD  = 32'hfefe0000
) (
  input  logic         clk,
  input  logic         rst,
  input  mem_req_type  mem_req,
  output mem_data_type mem_data,
  output logic         busy,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count
);

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  mem_ctrl_state_type    state_reg, state_next;
  logic [7:0]            cnt_reg, cnt_next;
  logic [LINES_LOG2-1:0] idx_reg, idx_next;
  logic [127:0]          data_reg, data_next;
  logic                  rw_reg, rw_next;
  logic [31:0]           rd_count_reg, rd_count_next;
  logic [31:0]           wr_count_reg, wr_count_next;
  logic                  commit;
  logic                  store_we, store_re;
  logic [127:0]          store_rdata;
  logic                  unused_addr_bits;

  // Offset bits and bits above the store depth do not select a line.
  assign unused_addr_bits = ^{mem_req.addr[31:LINES_LOG2+4], mem_req.addr[3:0]};

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    data_next     = data_reg;
    rw_next       = rw_reg;
    rd_count_next = rd_count_reg;
    wr_count_next = wr_count_reg;
    commit        = 1'b0;
    case (state_reg)
      MC_IDLE: begin
        if (mem_req.valid) begin
          idx_next   = mem_req.addr[LINES_LOG2+3:4];
          data_next  = mem_req.data;
          rw_next    = mem_req.rw;
          cnt_next   = CNT_LOAD;
          state_next = MC_WAIT;
        end
      end
      MC_WAIT: begin
        // A latency of one loads zero, so the first WAIT edge is the commit.
        if (cnt_reg == 8'd0) begin
          commit     = 1'b1;
          state_next = MC_RESP;
          if (rw_reg) begin
            wr_count_next = sat_inc(wr_count_reg);
          end else begin
            rd_count_next = sat_inc(rd_count_reg);
          end
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      MC_RESP: begin
        state_next = MC_IDLE;
      end
      default: begin
        state_next = MC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= MC_IDLE;
      cnt_reg      <= 8'd0;
      rd_count_reg <= 32'd0;
      wr_count_reg <= 32'd0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rd_count_reg <= rd_count_next;
      wr_count_reg <= wr_count_next;
    end
  end

  always_ff @(posedge clk) begin
    idx_reg  <= idx_next;
    data_reg <= data_next;
    rw_reg   <= rw_next;
  end

  // Reset on the commit edge must leave the store untouched.
  assign store_we = commit & rw_reg & ~rst;
  assign store_re = commit & ~rw_reg & ~rst;

  mem_line_store_upstream #(
    .LINES_LOG2(LINES_LOG2),
    .INIT_WORD (INIT_WORD)
  ) u_store (
    .clk  (clk),
    .rst  (rst),
    .index(idx_reg),
    .we   (store_we),
    .wdata(data_reg),
    .re   (store_re),
    .rdata(store_rdata)
  );

  assign mem_data.data  = store_rdata;
  assign mem_data.ready = (state_reg == MC_RESP);
  assign busy           = (state_reg != MC_IDLE);
  assign rd_count       = rd_count_reg;
  assign wr_count       = wr_count_reg;

endmodule

// File: tb/tb_line_mem_ctrl_upstream.sv
// Bench for line_mem_ctrl_upstream: directed and random line requests on a
// LATENCY=4 and a LATENCY=1 instance, checked against an array model.
module tb_line_mem_ctrl_upstream;
  import cache_def::*;

  localparam logic [31:0]  INIT      = 32'hfefe0000;
  localparam logic [127:0] INIT_LINE = {4{INIT}};

  logic clk = 1'b0;
  logic rst;
  logic sel;
  always #5 clk = ~clk;

  mem_req_type  req, req4, req1;
  mem_data_type md4, md1;
  logic         busy4, busy1;
  logic [31:0]  rdc4, wrc4, rdc1, wrc1;

  assign req4 = sel ? '0 : req;
  assign req1 = sel ? req : '0;

  line_mem_ctrl_upstream #(.LATENCY(4), .LINES_LOG2(10), .INIT_WORD(INIT)) dut4 (
    .clk(clk), .rst(rst), .mem_req(req4), .mem_data(md4),
    .busy(busy4), .rd_count(rdc4), .wr_count(wrc4)
  );

  line_mem_ctrl_upstream #(.LATENCY(1), .LINES_LOG2(10), .INIT_WORD(INIT)) dut1 (
    .clk(clk), .rst(rst), .mem_req(req1), .mem_data(md1),
    .busy(busy1), .rd_count(rdc1), .wr_count(wrc1)
  );

  logic         ready_o, busy_o;
  logic [127:0] data_o;
  logic [31:0]  rdc_o, wrc_o;
  assign ready_o = sel ? md1.ready : md4.ready;
  assign data_o  = sel ? md1.data  : md4.data;
  assign busy_o  = sel ? busy1 : busy4;
  assign rdc_o   = sel ? rdc1 : rdc4;
  assign wrc_o   = sel ? wrc1 : wrc4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(negedge clk) cyc++;

  // Reference: one line array per instance plus expected counters.
  logic [127:0] mm [2][1024];
  logic [31:0]  rd_exp [2];
  logic [31:0]  wr_exp [2];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd16) % 32'd1024);
  endfunction

  function automatic logic [31:0] sat_up(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 1;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rd_exp[s] = 32'd0;
      wr_exp[s] = 32'd0;
    end
  endtask

  // Drives one request starting at a negedge; returns at the negedge after the ready cycle.
  task automatic do_txn(input logic [31:0] a, input logic [127:0] d, input logic rw,
                        input bit garble, input string tag);
    int s   = sel ? 1 : 0;
    int lat = sel ? 1 : 4;
    int i   = idx_of(a);
    int n;
    req.addr  = a;
    req.data  = d;
    req.rw    = rw;
    req.valid = 1'b1;
    @(negedge clk);
    if (garble) begin
      req = '{addr: $urandom, data: {$urandom, $urandom, $urandom, $urandom},
              rw: 1'($urandom), valid: 1'($urandom)};
    end else begin
      req.valid = 1'b0;
    end
    check({tag, " busy_after_accept"}, 128'(busy_o), 128'(1));
    n = 1;
    while (!ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    req.valid = 1'b0;
    check({tag, " ready_latency"}, 128'(n), 128'(lat + 1));
    if (rw) begin
      mm[s][i]  = d;
      wr_exp[s] = sat_up(wr_exp[s]);
    end else begin
      rd_exp[s] = sat_up(rd_exp[s]);
      check({tag, " read_data"}, data_o, mm[s][i]);
    end
    check({tag, " rd_count"}, 128'(rdc_o), 128'(rd_exp[s]));
    check({tag, " wr_count"}, 128'(wrc_o), 128'(wr_exp[s]));
    @(negedge clk);
    check({tag, " ready_one_cycle"}, 128'({ready_o, busy_o}), 128'(0));
  endtask

  // Reset strikes at_n negedges after acceptance; at_n==LATENCY lands on the commit edge.
  task automatic rst_during_write(input logic [31:0] a, input logic [127:0] d,
                                  input int at_n, input string tag);
    int seen = 0;
    req.addr  = a;
    req.data  = d;
    req.rw    = 1'b1;
    req.valid = 1'b1;
    @(negedge clk);
    req.valid = 1'b0;
    repeat (at_n - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rd_exp[s] = 32'd0;
      wr_exp[s] = 32'd0;
    end
    check({tag, " busy_after_rst"}, 128'({ready_o, busy_o}), 128'(0));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
    check({tag, " no_ready"}, 128'(seen), 128'(0));
    check({tag, " wr_count"}, 128'(wrc_o), 128'(wr_exp[0]));
    do_txn(a, '0, 1'b0, 1'b0, {tag, " readback"});
  endtask

  initial begin
    int t1, t2, n;
    logic [31:0]  a;
    logic [127:0] d;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) mm[s][i] = INIT_LINE;
    sel = 1'b0;
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    do_reset();

    check("reset ready4", 128'(md4.ready), 128'(0));
    check("reset data4", md4.data, 128'(0));
    check("reset busy4", 128'(busy4), 128'(0));
    check("reset counts4", 128'({rdc4, wrc4}), 128'(0));
    check("reset ready/busy1", 128'({md1.ready, busy1}), 128'(0));

    do_txn(32'h0000_0040, '0, 1'b0, 1'b0, "init_read");
    check("init_read line", data_o, 128'hfefe0000_fefe0000_fefe0000_fefe0000);
    do_txn(32'h0000_0040, 128'h1, 1'b1, 1'b0, "write_40");
    do_txn(32'h0000_4040, '0, 1'b0, 1'b0, "read_wrap_4040");
    check("wrap data", data_o, 128'h1);

    // Write-back handoff: valid held, rw flipped to read in the ready cycle.
    a = 32'h0000_0230;
    d = {$urandom, $urandom, $urandom, $urandom};
    req = '{addr: a, data: d, rw: 1'b1, valid: 1'b1};
    n = 0;
    do begin @(negedge clk); n++; end while (!ready_o && n < 40);
    t1 = cyc;
    req.rw = 1'b0;
    mm[0][idx_of(a)] = d;
    wr_exp[0] = sat_up(wr_exp[0]);
    n = 0;
    do begin @(negedge clk); n++; end while (!ready_o && n < 40);
    t2 = cyc;
    req.valid = 1'b0;
    rd_exp[0] = sat_up(rd_exp[0]);
    // Second pulse starts LATENCY+1 cycles after the first pulse ends.
    check("handoff gap", 128'(t2 - t1), 128'(4 + 2));
    check("handoff data", data_o, d);
    check("handoff counts", 128'({rdc_o, wrc_o}), 128'({rd_exp[0], wr_exp[0]}));
    @(negedge clk);
    check("handoff idle", 128'({ready_o, busy_o}), 128'(0));

    rst_during_write(32'h0000_0080, {4{32'h1234_5678}}, 2, "rst_wait_80");
    rst_during_write(32'h0000_0090, {4{32'h0bad_f00d}}, 4, "rst_commit_90");

    // Random traffic with the request bus scrambled during WAIT.
    for (int k = 0; k < 30; k++) begin
      a = ($urandom & 32'hffff_c00f) | (32'($urandom_range(0, 7)) << 4);
      d = {$urandom, $urandom, $urandom, $urandom};
      do_txn(a, d, 1'($urandom), 1'($urandom), "rand4");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Saturation of the read counter.
    force dut4.rd_count_reg = 32'hffff_ffff;
    @(negedge clk);
    release dut4.rd_count_reg;
    rd_exp[0] = 32'hffff_ffff;
    check("sat preset", 128'(rdc4), 128'(32'hffff_ffff));
    do_txn(32'h0000_0100, '0, 1'b0, 1'b0, "sat_read");

    sel = 1'b1;
    @(negedge clk);
    do_txn(32'h0000_0050, '0, 1'b0, 1'b0, "lat1_read");
    for (int k = 0; k < 10; k++) begin
      a = ($urandom & 32'hffff_c00f) | (32'($urandom_range(0, 3)) << 4);
      d = {$urandom, $urandom, $urandom, $urandom};
      do_txn(a, d, 1'($urandom), 1'($urandom), "rand1");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
